rob_multiport: RTL and testbench

// - Parametrised reorder buffer: in-order retirement for the out-of-order core.
// - Sits between issue (allocation), ALU/LSB (writeback), register file (commit) and fetch (redirect).
// - Adds over the first generation: configurable depth and full slack, and a typed entry field in place of opcode decode.
// - Also adds writeback-supplied redirects, rename-time operand query ports and a registered store-commit handshake to the LSB.

---
 rtl/rob_multiport.sv | 180 ++++++++++++++++++
 tb/tb_rob_multiport.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rob_multiport: parametrised reorder buffer, in-order commit, redirect/flush |
// | Option ROB_WB_BYPASS_EN: query ports forward same-cycle writebacks.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rob_multiport #(
  parameter int DEPTH      = 32,
  parameter int IDX_W      = 5,
  parameter int XLEN       = 32,
  parameter int FULL_SLACK = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [1:0]       issue_kind,
  input  logic [4:0]       issue_rd,
  output logic [IDX_W-1:0] issue_idx,
  output logic             rob_full,
  output logic [IDX_W-1:0] rob_head,
  input  logic             alu_wb_valid,
  input  logic [IDX_W-1:0] alu_wb_idx,
  input  logic [XLEN-1:0]  alu_wb_value,
  input  logic             alu_wb_redirect,
  input  logic [XLEN-1:0]  alu_wb_target,
  input  logic             lsb_wb_valid,
  input  logic [IDX_W-1:0] lsb_wb_idx,
  input  logic [XLEN-1:0]  lsb_wb_value,
  input  logic [IDX_W-1:0] qry_a_idx,
  input  logic [IDX_W-1:0] qry_b_idx,
  output logic             qry_a_ready,
  output logic             qry_b_ready,
  output logic [XLEN-1:0]  qry_a_value,
  output logic [XLEN-1:0]  qry_b_value,
  output logic             commit_valid,
  output logic [IDX_W-1:0] commit_idx,
  output logic [4:0]       commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic             store_commit,
  output logic             pc_change,
  output logic [XLEN-1:0]  pc_goal,
  output logic             flush
);

  localparam logic [1:0]     KIND_REG = 2'd0;
  localparam logic [1:0]     KIND_BR  = 2'd1;
  localparam logic [1:0]     KIND_JMP = 2'd2;
  localparam logic [1:0]     KIND_ST  = 2'd3;
  localparam logic [IDX_W:0] DEPTH_C  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] SLACK_C  = (IDX_W+1)'(FULL_SLACK);

  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [DEPTH-1:0] redir_q;
  logic [1:0]       kind_q   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [XLEN-1:0]  value_q  [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];

  logic [IDX_W-1:0] alu_off, lsb_off;
  logic             alu_acc, lsb_acc, issue_acc, commit_go, redirect_go, full_d;
  logic [1:0]       head_kind;

  // An index is live when its distance from head is below the occupancy.
  assign alu_off     = alu_wb_idx - head_q;
  assign lsb_off     = lsb_wb_idx - head_q;
  assign alu_acc     = rdy_in && alu_wb_valid && !flush && ({1'b0, alu_off} < count_q);
  assign lsb_acc     = rdy_in && lsb_wb_valid && !flush && ({1'b0, lsb_off} < count_q)
                       && !(alu_acc && (alu_wb_idx == lsb_wb_idx));
  assign issue_acc   = rdy_in && issue_valid && !flush && (count_q != DEPTH_C);
  assign head_kind   = kind_q[head_q];
  assign commit_go   = rdy_in && (count_q != '0) && ready_q[head_q];
  assign redirect_go = commit_go && redir_q[head_q]
                       && ((head_kind == KIND_BR) || (head_kind == KIND_JMP));

  assign issue_idx = tail_q;
  assign rob_head  = head_q;

  always_comb begin
    ready_d = ready_q;
    if (issue_acc) ready_d[tail_q]     = 1'b0;
    if (alu_acc)   ready_d[alu_wb_idx] = 1'b1;
    if (lsb_acc)   ready_d[lsb_wb_idx] = 1'b1;
    if (redirect_go) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{IDX_W{1'b0}}, issue_acc} - {{IDX_W{1'b0}}, commit_go};
    end
    full_d = (DEPTH_C - count_d) <= SLACK_C;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ready_q      <= '0;
      rob_full     <= 1'b0;
      commit_valid <= 1'b0;
      commit_idx   <= '0;
      commit_rd    <= '0;
      commit_value <= '0;
      store_commit <= 1'b0;
      pc_change    <= 1'b0;
      pc_goal      <= '0;
      flush        <= 1'b0;
    end else if (!rdy_in) begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      pc_change    <= 1'b0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= commit_go && ((head_kind == KIND_REG) || (head_kind == KIND_JMP));
      store_commit <= commit_go && (head_kind == KIND_ST);
      pc_change    <= redirect_go;
      flush        <= redirect_go;
      if (commit_go) begin
        commit_idx   <= head_q;
        commit_rd    <= rd_q[head_q];
        commit_value <= value_q[head_q];
      end
      if (redirect_go) pc_goal <= target_q[head_q];
      rob_full <= full_d;
      count_q  <= count_d;
      // A redirecting commit discards every younger entry, including this cycle's issue.
      if (redirect_go) begin
        head_q  <= '0;
        tail_q  <= '0;
        ready_q <= '0;
      end else begin
        if (commit_go) head_q <= head_q + {{(IDX_W-1){1'b0}}, 1'b1};
        if (issue_acc) tail_q <= tail_q + {{(IDX_W-1){1'b0}}, 1'b1};
        ready_q <= ready_d;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (issue_acc) begin
      kind_q[tail_q] <= issue_kind;
      rd_q[tail_q]   <= issue_rd;
    end
    if (alu_acc) begin
      value_q[alu_wb_idx]  <= alu_wb_value;
      redir_q[alu_wb_idx]  <= alu_wb_redirect;
      target_q[alu_wb_idx] <= alu_wb_target;
    end
    if (lsb_acc) begin
      value_q[lsb_wb_idx] <= lsb_wb_value;
      redir_q[lsb_wb_idx] <= 1'b0;
    end
  end

  always_comb begin
    qry_a_ready = ready_q[qry_a_idx];
    qry_a_value = value_q[qry_a_idx];
    qry_b_ready = ready_q[qry_b_idx];
    qry_b_value = value_q[qry_b_idx];
`ifdef ROB_WB_BYPASS_EN
    if (alu_acc && (alu_wb_idx == qry_a_idx)) begin
      qry_a_ready = 1'b1;
      qry_a_value = alu_wb_value;
    end else if (lsb_acc && (lsb_wb_idx == qry_a_idx)) begin
      qry_a_ready = 1'b1;
      qry_a_value = lsb_wb_value;
    end
    if (alu_acc && (alu_wb_idx == qry_b_idx)) begin
      qry_b_ready = 1'b1;
      qry_b_value = alu_wb_value;
    end else if (lsb_acc && (lsb_wb_idx == qry_b_idx)) begin
      qry_b_ready = 1'b1;
      qry_b_value = lsb_wb_value;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rob_multiport: directed + random stimulus against a queue-based model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rob_multiport;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int XLEN  = 32;
  localparam int SLACK = 3;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, issue_valid;
  logic [1:0] issue_kind;
  logic [4:0] issue_rd;
  logic [IDX_W-1:0] issue_idx, rob_head;
  logic rob_full;
  logic alu_wb_valid, alu_wb_redirect, lsb_wb_valid;
  logic [IDX_W-1:0] alu_wb_idx, lsb_wb_idx, qry_a_idx, qry_b_idx;
  logic [XLEN-1:0] alu_wb_value, alu_wb_target, lsb_wb_value;
  logic qry_a_ready, qry_b_ready;
  logic [XLEN-1:0] qry_a_value, qry_b_value;
  logic commit_valid, store_commit, pc_change, flush;
  logic [IDX_W-1:0] commit_idx;
  logic [4:0] commit_rd;
  logic [XLEN-1:0] commit_value, pc_goal;

  rob_multiport #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .FULL_SLACK(SLACK)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .issue_idx(issue_idx), .rob_full(rob_full), .rob_head(rob_head),
    .alu_wb_valid(alu_wb_valid), .alu_wb_idx(alu_wb_idx), .alu_wb_value(alu_wb_value),
    .alu_wb_redirect(alu_wb_redirect), .alu_wb_target(alu_wb_target),
    .lsb_wb_valid(lsb_wb_valid), .lsb_wb_idx(lsb_wb_idx), .lsb_wb_value(lsb_wb_value),
    .qry_a_idx(qry_a_idx), .qry_b_idx(qry_b_idx),
    .qry_a_ready(qry_a_ready), .qry_b_ready(qry_b_ready),
    .qry_a_value(qry_a_value), .qry_b_value(qry_b_value),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_rd(commit_rd),
    .commit_value(commit_value), .store_commit(store_commit),
    .pc_change(pc_change), .pc_goal(pc_goal), .flush(flush)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          idx;
    int          kind;
    int          rd;
    bit          rdy;
    logic [31:0] val;
    bit          redir;
    logic [31:0] tgt;
  } ent_t;

  ent_t mq[$];
  int   m_head, m_tail;
  bit   e_cv, e_sc, e_pcc, e_fl, e_full;
  int   e_cidx, e_crd;
  logic [31:0] e_cval, e_goal;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   auto_qry = 1'b1;
  int   clog_rd[$];
  int   clog_cyc[$];
  logic [31:0] clog_val[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input int idx);
    foreach (mq[i]) if (mq[i].idx == idx) return i;
    return -1;
  endfunction

  function automatic bit alu_taken();
    return rdy_in && alu_wb_valid && !e_fl && (find(alu_wb_idx) >= 0);
  endfunction

  function automatic bit lsb_taken();
    return rdy_in && lsb_wb_valid && !e_fl && (find(lsb_wb_idx) >= 0)
           && !(alu_taken() && alu_wb_idx == lsb_wb_idx);
  endfunction

  task automatic qry_one(input string tag, input int idx, input logic r, input logic [31:0] v);
    int   i;
    bit   er;
    logic [31:0] ev;
    i = find(idx);
    if (i >= 0) begin
      er = mq[i].rdy;
      ev = mq[i].val;
`ifdef ROB_WB_BYPASS_EN
      if (alu_taken() && alu_wb_idx == idx) begin
        er = 1'b1; ev = alu_wb_value;
      end else if (lsb_taken() && lsb_wb_idx == idx) begin
        er = 1'b1; ev = lsb_wb_value;
      end
`endif
      chk({tag, "_ready"}, r, er);
      if (er) chk({tag, "_value"}, v, ev);
    end
  endtask

  // Reference behaviour of one clock edge, applied to the entry queue.
  task automatic model_edge();
    bit   cur_fl, com, redir, iss_ok;
    int   ai, li;
    ent_t c;
    cur_fl = e_fl;
    if (!rdy_in) begin
      e_cv = 0; e_sc = 0; e_pcc = 0; e_fl = 0;
      return;
    end
    com = (mq.size() > 0) && mq[0].rdy;
    redir = 0; e_cv = 0; e_sc = 0;
    if (com) begin
      c = mq[0];
      e_cv   = (c.kind == 0) || (c.kind == 2);
      e_sc   = (c.kind == 3);
      redir  = ((c.kind == 1) || (c.kind == 2)) && c.redir;
      e_cidx = c.idx; e_crd = c.rd; e_cval = c.val;
      if (redir) e_goal = c.tgt;
    end
    e_pcc = redir; e_fl = redir;
    ai = (!cur_fl && alu_wb_valid) ? find(alu_wb_idx) : -1;
    if (ai >= 0) begin
      mq[ai].rdy = 1; mq[ai].val = alu_wb_value;
      mq[ai].redir = alu_wb_redirect; mq[ai].tgt = alu_wb_target;
    end
    li = (cur_fl || !lsb_wb_valid || (ai >= 0 && lsb_wb_idx == alu_wb_idx)) ? -1 : find(lsb_wb_idx);
    if (li >= 0) begin
      mq[li].rdy = 1; mq[li].val = lsb_wb_value; mq[li].redir = 0;
    end
    iss_ok = issue_valid && (mq.size() < DEPTH) && !cur_fl;
    if (redir) begin
      mq.delete(); m_head = 0; m_tail = 0;
    end else begin
      if (com) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (iss_ok) begin
        mq.push_back('{idx: m_tail, kind: int'(issue_kind), rd: int'(issue_rd),
                       rdy: 1'b0, val: 32'h0, redir: 1'b0, tgt: 32'h0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    e_full = (DEPTH - mq.size()) <= SLACK;
  endtask

  task automatic post_check();
    chk("commit_valid", commit_valid, e_cv);
    chk("store_commit", store_commit, e_sc);
    chk("pc_change", pc_change, e_pcc);
    chk("flush", flush, e_fl);
    chk("rob_full", rob_full, e_full);
    chk("issue_idx", issue_idx, m_tail);
    chk("rob_head", rob_head, m_head);
    if (e_cv) begin
      chk("commit_idx", commit_idx, e_cidx);
      chk("commit_rd", commit_rd, e_crd);
      chk("commit_value", commit_value, e_cval);
    end
    if (e_pcc) chk("pc_goal", pc_goal, e_goal);
  endtask

  // Inputs are driven 1 time unit after a rising edge; cyc() finishes at the same phase.
  task automatic cyc();
    if (auto_qry && mq.size() > 0) begin
      qry_a_idx = IDX_W'(mq[$urandom_range(mq.size() - 1)].idx);
      qry_b_idx = IDX_W'(mq[$urandom_range(mq.size() - 1)].idx);
    end
    #2;
    qry_one("qry_a", qry_a_idx, qry_a_ready, qry_a_value);
    qry_one("qry_b", qry_b_idx, qry_b_ready, qry_b_value);
    model_edge();
    @(posedge clk_in);
    #1;
    post_check();
    if (commit_valid) begin
      clog_rd.push_back(int'(commit_rd));
      clog_val.push_back(commit_value);
      clog_cyc.push_back(cycle);
    end
    cycle++;
  endtask

  task automatic idle();
    rdy_in = 1; issue_valid = 0; issue_kind = 0; issue_rd = 0;
    alu_wb_valid = 0; alu_wb_idx = 0; alu_wb_value = 0; alu_wb_redirect = 0; alu_wb_target = 0;
    lsb_wb_valid = 0; lsb_wb_idx = 0; lsb_wb_value = 0;
  endtask

  task automatic do_reset();
    rst_in = 1;
    #3;
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_store_commit", store_commit, 0);
    chk("rst_pc_change", pc_change, 0);
    chk("rst_flush", flush, 0);
    chk("rst_rob_full", rob_full, 0);
    chk("rst_issue_idx", issue_idx, 0);
    chk("rst_rob_head", rob_head, 0);
    chk("rst_pc_goal", pc_goal, 0);
    chk("rst_commit_value", commit_value, 0);
    mq.delete(); m_head = 0; m_tail = 0;
    e_cv = 0; e_sc = 0; e_pcc = 0; e_fl = 0; e_full = 0;
    @(posedge clk_in);
    #1;
    rst_in = 0;
  endtask

  task automatic issue(input int kind, input int rd);
    issue_valid = 1; issue_kind = 2'(kind); issue_rd = 5'(rd);
  endtask

  task automatic alu(input int idx, input logic [31:0] v, input bit r, input logic [31:0] t);
    alu_wb_valid = 1; alu_wb_idx = IDX_W'(idx); alu_wb_value = v;
    alu_wb_redirect = r; alu_wb_target = t;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sidx, h0, ncommit;
    bit seen;
    rst_in = 1; qry_a_idx = 0; qry_b_idx = 0;
    idle();
    do_reset();

    // In-order retirement of out-of-order writebacks.
    idle(); issue(0, 1); cyc();
    issue(0, 2); cyc();
    issue(0, 3); cyc();
    idle(); alu(2, 10, 0, 0); cyc();
    idle(); alu(0, 20, 0, 0); cyc();
    idle(); alu(1, 30, 0, 0); cyc();
    idle(); repeat (4) cyc();
    chk("order_count", clog_rd.size(), 3);
    if (clog_rd.size() == 3) begin
      chk("order_rd0", clog_rd[0], 1);  chk("order_val0", clog_val[0], 20);
      chk("order_rd1", clog_rd[1], 2);  chk("order_val1", clog_val[1], 30);
      chk("order_rd2", clog_rd[2], 3);  chk("order_val2", clog_val[2], 10);
      chk("order_back2back", clog_cyc[2] - clog_cyc[0], 2);
    end

    // Fill to capacity with no commits.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); issue(0, i + 1); cyc();
    end
    chk("full_after5", rob_full, 1);
    for (int i = 5; i < 8; i++) begin
      idle(); issue(0, i + 1); cyc();
    end
    chk("full_tail8", issue_idx, 0);
    idle(); issue(0, 9); cyc();
    chk("full_9th_ignored", issue_idx, 0);
    chk("full_still", rob_full, 1);
    for (int i = 0; i < 8; i++) begin
      idle(); alu(i, 32'h100 + i, 0, 0); cyc();
    end
    idle(); repeat (3) cyc();

    // Redirecting branch squashes younger ready entries.
    do_reset();
    idle(); issue(0, 5); cyc();
    issue(1, 0); cyc();
    issue(0, 6); cyc();
    issue(0, 7); cyc();
    idle(); alu(2, 32'h22, 0, 0); cyc();
    idle(); alu(3, 32'h33, 0, 0); cyc();
    idle(); alu(1, 32'h0, 1, 32'h1000); cyc();
    idle(); alu(0, 32'h77, 0, 0); cyc();
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      idle(); cyc();
      seen = pc_change;
    end
    chk("redirect_seen", pc_change, 1);
    chk("redirect_goal", pc_goal, 32'h1000);
    chk("redirect_flush", flush, 1);
    chk("redirect_tail", issue_idx, 0);
    clog_rd.delete(); clog_val.delete(); clog_cyc.delete();
    idle(); issue(0, 9); cyc();
    chk("flush_one_cycle", flush, 0);
    chk("flush_issue_ignored", issue_idx, 0);
    idle(); repeat (3) cyc();
    chk("no_commit_after_flush", clog_rd.size(), 0);

    // Store retirement.
    sidx = m_tail;
    idle(); issue(3, 0); cyc();
    idle(); lsb_wb_valid = 1; lsb_wb_idx = IDX_W'(sidx); lsb_wb_value = 32'hdead; cyc();
    idle(); cyc();
    chk("store_commit_pulse", store_commit, 1);
    chk("store_no_commit_valid", commit_valid, 0);

    // Wrap-around with 20 issue/commit pairs.
    clog_rd.delete(); clog_val.delete(); clog_cyc.delete();
    h0 = m_head;
    for (int k = 0; k < 20; k++) begin
      idle(); issue(0, (k % 31) + 1);
      if (mq.size() > 0) alu(mq[$].idx, 32'(k), 0, 0);
      cyc();
    end
    idle(); if (mq.size() > 0) alu(mq[$].idx, 32'd99, 0, 0);
    cyc();
    idle(); repeat (3) cyc();
    ncommit = clog_rd.size();
    chk("wrap_commits", ncommit, 20);
    chk("wrap_head", rob_head, (h0 + 20) % DEPTH);

    // Same-cycle query of a writeback target.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); issue(0, i + 1); cyc();
    end
    auto_qry = 0;
    idle(); qry_a_idx = 4; qry_b_idx = 3; alu(4, 32'h55, 0, 0);
    #2;
`ifdef ROB_WB_BYPASS_EN
    chk("bypass_ready", qry_a_ready, 1);
    chk("bypass_value", qry_a_value, 32'h55);
`else
    chk("nobypass_ready", qry_a_ready, 0);
`endif
    cyc();
    idle(); #2;
    chk("qry_next_ready", qry_a_ready, 1);
    chk("qry_next_value", qry_a_value, 32'h55);
    cyc();
    auto_qry = 1;

    // Asynchronous reset with live entries.
    chk("live_before_reset", mq.size(), 5);
    do_reset();
    idle(); cyc();
    chk("post_reset_full", rob_full, 0);
    chk("post_reset_tail", issue_idx, 0);

    // Random traffic including stalls and redirects.
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy_in = ($urandom_range(9) != 0);
      if ($urandom_range(9) < 6) issue($urandom_range(3), $urandom_range(31));
      if ($urandom_range(1) == 1) begin
        if (mq.size() > 0 && $urandom_range(3) != 0)
          alu(mq[$urandom_range(mq.size() - 1)].idx, $urandom, ($urandom_range(11) == 0), $urandom);
        else
          alu($urandom_range(DEPTH - 1), $urandom, ($urandom_range(11) == 0), $urandom);
      end
      if ($urandom_range(9) < 4) begin
        lsb_wb_valid = 1;
        lsb_wb_value = $urandom;
        if (mq.size() > 0 && $urandom_range(3) != 0)
          lsb_wb_idx = IDX_W'(mq[$urandom_range(mq.size() - 1)].idx);
        else
          lsb_wb_idx = IDX_W'($urandom_range(DEPTH - 1));
      end
      cyc();
    end

    idle(); repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
